// File: rtl/simd_add_pipe.sv
// ---------------------------------------------------------------------------
// simd_add_pipe
//
// Lane-partitioned add/subtract on a DATA_W-bit word. The word is treated as
// one full-width lane or as 2, 4, ... equal lanes down to LANE_MIN bits. The
// carry chain is cut only at active lane boundaries. Optional per-lane signed
// saturation and per-lane carry-out / signed-overflow flags are provided. The
// arithmetic is done in the first register stage; the remaining PIPE-1
// stages are plain pass-through registers under a single global stall.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset, clears all stages
//   in_valid     operand beat valid
//   in_ready     block can accept a beat this cycle (low only while stalled)
//   in_mode      lane width select: lane width = LANE_MIN << in_mode
//   in_sub       1 = A - B, 0 = A + B
//   in_sat       1 = saturate each lane on signed overflow
//   in_a, in_b   operands
//   out_valid    result valid
//   out_ready    downstream accepts the result
//   out_sum      lane-wise result
//   out_cout     carry-out per minimum lane (only at the top min-lane of
//                each active lane, 0 elsewhere)
//   out_ovf      signed overflow per minimum lane (same placement)
//   out_illegal  beat carried a lane width wider than DATA_W
// ---------------------------------------------------------------------------
module simd_add_pipe #(
    parameter int DATA_W   = 32,
    parameter int LANE_MIN = 8,
    parameter int NLANE    = DATA_W / LANE_MIN,
    parameter int MODE_W   = 2,
    parameter int PIPE     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    input  logic              in_sub,
    input  logic              in_sat,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [NLANE-1:0]  out_cout,
    output logic [NLANE-1:0]  out_ovf,
    output logic              out_illegal
);

    localparam int LOG_NL = $clog2(NLANE);

    // Stage-1 combinational results
    logic              w_illegal;
    logic [DATA_W-1:0] w_raw_sum;
    logic [NLANE-1:0]  w_raw_cout;
    logic [NLANE-1:0]  w_raw_ovf;
    logic [NLANE-1:0]  w_top;
    logic [DATA_W-1:0] w_sum;
    logic [NLANE-1:0]  w_cout;
    logic [NLANE-1:0]  w_ovf;
    logic              w_stall;

    // Pipeline registers; index PIPE-1 drives the outputs
    logic [PIPE-1:0]   r_valid;
    logic [DATA_W-1:0] r_sum     [PIPE];
    logic [NLANE-1:0]  r_cout    [PIPE];
    logic [NLANE-1:0]  r_ovf     [PIPE];
    logic              r_illegal [PIPE];

    always_comb begin : arith
        logic                carry;
        logic [LANE_MIN:0]   part;
        logic [LANE_MIN-1:0] a_l;
        logic [LANE_MIN-1:0] b_l;
        logic                a_msb;
        int                  grp;
        int                  t;

        carry      = 1'b0;
        part       = '0;
        a_l        = '0;
        b_l        = '0;
        a_msb      = 1'b0;
        t          = 0;
        w_raw_sum  = '0;
        w_raw_cout = '0;
        w_raw_ovf  = '0;
        w_top      = '0;
        w_sum      = '0;
        w_cout     = '0;
        w_ovf      = '0;

        w_illegal = (32'(in_mode) > LOG_NL);
        // Number of minimum lanes per active lane; forced to 1 for an illegal
        // mode so every index below stays in range (result is zeroed anyway).
        grp = w_illegal ? 1 : (1 << in_mode);

        // Ripple through minimum lanes; the carry is re-seeded with in_sub at
        // the bottom of every active lane, so internal seams of a wide lane
        // still propagate.
        for (int j = 0; j < NLANE; j++) begin
            a_l = in_a[j*LANE_MIN +: LANE_MIN];
            b_l = in_b[j*LANE_MIN +: LANE_MIN] ^ {LANE_MIN{in_sub}};
            if ((j & (grp - 1)) == 0) begin
                carry = in_sub;
            end
            part = {1'b0, a_l} + {1'b0, b_l} + {{LANE_MIN{1'b0}}, carry};
            carry = part[LANE_MIN];
            w_raw_sum[j*LANE_MIN +: LANE_MIN] = part[LANE_MIN-1:0];
            w_raw_cout[j] = carry;
            // Only meaningful at the top min-lane of an active lane
            w_raw_ovf[j]  = (a_l[LANE_MIN-1] == b_l[LANE_MIN-1]) &&
                            (part[LANE_MIN-1] != a_l[LANE_MIN-1]);
            w_top[j]      = ((j & (grp - 1)) == (grp - 1));
        end

        // Saturation: every min-lane looks at the overflow and A sign of the
        // top min-lane of the active lane it belongs to.
        for (int j = 0; j < NLANE; j++) begin
            t     = j | (grp - 1);
            a_msb = in_a[t*LANE_MIN + LANE_MIN - 1];
            if (in_sat && w_raw_ovf[t]) begin
                if (w_top[j]) begin
                    w_sum[j*LANE_MIN +: LANE_MIN] = {a_msb, {(LANE_MIN-1){~a_msb}}};
                end else begin
                    w_sum[j*LANE_MIN +: LANE_MIN] = {LANE_MIN{~a_msb}};
                end
            end else begin
                w_sum[j*LANE_MIN +: LANE_MIN] = w_raw_sum[j*LANE_MIN +: LANE_MIN];
            end
        end

        w_cout = w_raw_cout & w_top;
        w_ovf  = w_raw_ovf & w_top;

        if (w_illegal) begin
            w_sum  = '0;
            w_cout = '0;
            w_ovf  = '0;
        end
    end

    // Global stall: nothing moves while the output is held.
    assign w_stall  = r_valid[PIPE-1] & ~out_ready;
    assign in_ready = ~w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int s = 0; s < PIPE; s++) begin
                r_sum[s]     <= '0;
                r_cout[s]    <= '0;
                r_ovf[s]     <= '0;
                r_illegal[s] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_valid[0]   <= in_valid;
            r_sum[0]     <= w_sum;
            r_cout[0]    <= w_cout;
            r_ovf[0]     <= w_ovf;
            r_illegal[0] <= w_illegal;
            for (int s = 1; s < PIPE; s++) begin
                r_valid[s]   <= r_valid[s-1];
                r_sum[s]     <= r_sum[s-1];
                r_cout[s]    <= r_cout[s-1];
                r_ovf[s]     <= r_ovf[s-1];
                r_illegal[s] <= r_illegal[s-1];
            end
        end
    end

    assign out_valid   = r_valid[PIPE-1];
    assign out_sum     = r_sum[PIPE-1];
    assign out_cout    = r_cout[PIPE-1];
    assign out_ovf     = r_ovf[PIPE-1];
    assign out_illegal = r_illegal[PIPE-1];

endmodule
